// File: rtl/lat_dmem_pkg.sv
// Shared encodings, FSM states and default MMIO addresses for the lat_dmem data-memory slave.
package lat_dmem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_BYTE     = 2'b10,
        SZ_BYTE_ALT = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_e;

    localparam logic [31:0] DEF_STDOUT_ADDR = 32'hf000_0000;
    localparam logic [31:0] DEF_EXIT_ADDR   = 32'hff00_0000;

    // Index of the first byte touched within its word (byte 0 = lowest address).
    function automatic logic [1:0] first_byte(size_e size, logic [1:0] lo);
        logic [1:0] idx;
        case (size)
            SZ_WORD: idx = lo;
            SZ_HALF: idx = 2'd2 - lo;
            default: idx = 2'd3 - lo;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/lat_dmem_lane.sv
// Byte-lane steering between the bus (DDT) and one storage word, shared by load and store paths.
module lat_dmem_lane
    import lat_dmem_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [1:0]  first;
    logic [1:0]  last;
    logic [1:0]  lane;
    logic [4:0]  sh;
    logic [31:0] rshift;

    // Storage word keeps byte 0 in [31:24]; lane n of the word is bits [8n+7:8n].
    always_comb begin
        first  = first_byte(size, lo);
        last   = (size == SZ_HALF) ? first + 2'd1 : first;
        lane   = 2'd3 - last;
        sh     = {lane, 3'b000};
        rshift = rword >> sh;
        // NOTE: every output gets a default before the case so no path can infer a latch.
        misaligned = 1'b0;
        be         = 4'h0;
        wword      = '0;
        rdata      = '0;
        case (size)
            SZ_WORD: begin
                misaligned = (lo != 2'b00);
                be         = 4'hf;
                wword      = wdata;
                rdata      = rword;
            end
            SZ_HALF: begin
                misaligned = lo[0];
                be         = 4'b0011 << lane;
                wword      = {16'h0, wdata[15:0]} << sh;
                rdata      = {16'h0, rshift[15:0]};
            end
            default: begin
                be         = 4'b0001 << lane;
                wword      = {24'h0, wdata[7:0]} << sh;
                rdata      = {24'h0, rshift[7:0]};
            end
        endcase
    end

endmodule

// File: rtl/lat_dmem_slave.sv
// Clocked data-memory slave with configurable latency and big-endian lane map.
// Define LAT_DMEM_MMIO_EN to enable the stdout/exit store ports.
module lat_dmem_slave
    import lat_dmem_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH_B     = 65536,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] STDOUT_ADDR = DEF_STDOUT_ADDR,
    parameter logic [31:0] EXIT_ADDR   = DEF_EXIT_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MREQ,
    input  logic              WRITE,
    input  logic [1:0]        SIZE,
    input  logic [31:0]       DAD,
    input  logic [DATA_W-1:0] DDT_in,
    output logic [DATA_W-1:0] DDT_out,
    output logic              DDT_oe,
    output logic              ACKD_n,
    output logic              err,
    output logic              con_valid,
    output logic [7:0]        con_char,
    output logic              exit_req
);

    localparam int ADDR_W = $clog2(DEPTH_B);
    localparam int WIDX_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;
    localparam int WORDS  = DEPTH_B / 4;

    state_e             state, state_nx;
    logic [3:0]         cnt, cnt_nx;
    logic               wr_q;
    size_e              size_q;
    logic [31:0]        dad_q;

    logic               enter_ack;
    logic               acc_wr;
    size_e              acc_size;
    logic [31:0]        acc_dad;
    logic [31:0]        off;
    logic               in_range;
    logic [WIDX_W-1:0]  widx;
    logic               misaligned;
    logic [3:0]         be;
    logic [31:0]        wword, rword, rdata;
    logic               stdout_hit, exit_hit, mmio_hit;
    logic               acc_err, do_store;

    logic [31:0]        mem [WORDS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            wr_q   <= 1'b0;
            size_q <= SZ_WORD;
            dad_q  <= '0;
        end else begin
            // NOTE: sequential state always uses <= so every register sees pre-edge values.
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && MREQ) begin
                wr_q   <= WRITE;
                size_q <= size_e'(SIZE);
                dad_q  <= DAD;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        enter_ack = 1'b0;
        case (state)
            IDLE: begin
                if (MREQ) begin
                    cnt_nx = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_nx  = ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!MREQ) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nx  = ACK;
                        enter_ack = 1'b1;
                    end
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A zero-wait access enters ACK straight from IDLE, before the capture registers load.
    assign acc_wr   = (state == IDLE) ? WRITE : wr_q;
    assign acc_size = (state == IDLE) ? size_e'(SIZE) : size_q;
    assign acc_dad  = (state == IDLE) ? DAD : dad_q;

    assign off      = acc_dad - BASE_ADDR;
    assign in_range = (off < 32'(DEPTH_B));
    assign widx     = WIDX_W'(off >> 2);
    assign rword    = mem[widx];

    lat_dmem_lane u_lane (
        .size       (acc_size),
        .lo         (off[1:0]),
        .wdata      (DDT_in),
        .rword      (rword),
        .misaligned (misaligned),
        .be         (be),
        .wword      (wword),
        .rdata      (rdata)
    );

`ifdef LAT_DMEM_MMIO_EN
    assign stdout_hit = acc_wr && (acc_dad == STDOUT_ADDR);
    assign exit_hit   = acc_wr && (acc_dad == EXIT_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            con_valid <= 1'b0;
            con_char  <= '0;
            exit_req  <= 1'b0;
        end else begin
            con_valid <= enter_ack && stdout_hit;
            if (enter_ack && stdout_hit) con_char <= DDT_in[7:0];
            if (enter_ack && exit_hit)   exit_req <= 1'b1;
        end
    end
`else
    logic unused_mmio_addrs;
    assign unused_mmio_addrs = ^{STDOUT_ADDR, EXIT_ADDR};
    assign stdout_hit        = 1'b0;
    assign exit_hit          = 1'b0;
    assign con_valid         = 1'b0;
    assign con_char          = '0;
    assign exit_req          = 1'b0;
`endif

    assign mmio_hit = stdout_hit || exit_hit;
    assign acc_err  = !mmio_hit && (misaligned || !in_range);
    assign do_store = enter_ack && acc_wr && !acc_err && !mmio_hit;

    // NOTE: storage has no reset; only control and bus outputs are initialised.
    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (do_store && be[j]) mem[widx][8*j +: 8] <= wword[8*j +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ACKD_n  <= 1'b1;
            DDT_out <= '0;
            DDT_oe  <= 1'b0;
            err     <= 1'b0;
        end else begin
            ACKD_n  <= !enter_ack;
            DDT_oe  <= enter_ack && !acc_wr;
            DDT_out <= (enter_ack && !acc_wr && !acc_err) ? rdata : '0;
            if (enter_ack && acc_err) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lat_dmem_slave.sv
// Self-checking bench for lat_dmem_slave: three instances at LATENCY 1, 3 and 4 against a byte-array model.
module tb_lat_dmem_slave;
    import lat_dmem_pkg::*;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          DEPTH  = 1024;
    localparam int          NDUT   = 3;
    localparam logic [31:0] STDOUT = DEF_STDOUT_ADDR;
    localparam logic [31:0] EXIT   = DEF_EXIT_ADDR;
`ifdef LAT_DMEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    typedef struct {
        int          d;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mreq  [NDUT];
    logic        write [NDUT];
    logic [1:0]  size  [NDUT];
    logic [31:0] dad   [NDUT];
    logic [31:0] din   [NDUT];
    logic [31:0] dout  [NDUT];
    logic        oe    [NDUT];
    logic        ackn  [NDUT];
    logic        err   [NDUT];
    logic        cv    [NDUT];
    logic [7:0]  cc    [NDUT];
    logic        ex    [NDUT];

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem_m   [NDUT][DEPTH];
    bit         known_m [NDUT][DEPTH];
    bit         err_m   [NDUT];
    bit         ex_m    [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        lat_dmem_slave #(
            .DEPTH_B   (DEPTH),
            .BASE_ADDR (BASE),
            .LATENCY   ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .MREQ      (mreq[g]),
            .WRITE     (write[g]),
            .SIZE      (size[g]),
            .DAD       (dad[g]),
            .DDT_in    (din[g]),
            .DDT_out   (dout[g]),
            .DDT_oe    (oe[g]),
            .ACKD_n    (ackn[g]),
            .err       (err[g]),
            .con_valid (cv[g]),
            .con_char  (cc[g]),
            .exit_req  (ex[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                         input logic [31:0] mask);
        n_vec++;
        if ((act & mask) !== (exp & mask)) begin
            n_err++;
            $display("FAIL %s: got %08h, want %08h (mask %08h)", name, act, exp, mask);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("%s_d%0d_ackn", tag, d), 32'(ackn[d]), 32'd1, '1);
            check($sformatf("%s_d%0d_dout", tag, d), dout[d], 32'd0, '1);
            check($sformatf("%s_d%0d_oe", tag, d), 32'(oe[d]), 32'd0, '1);
            check($sformatf("%s_d%0d_err", tag, d), 32'(err[d]), 32'd0, '1);
            check($sformatf("%s_d%0d_cv", tag, d), 32'(cv[d]), 32'd0, '1);
            check($sformatf("%s_d%0d_cc", tag, d), 32'(cc[d]), 32'd0, '1);
            check($sformatf("%s_d%0d_ex", tag, d), 32'(ex[d]), 32'd0, '1);
        end
    endtask

    // One complete bus transaction, checked against the byte-array model.
    task automatic access(input int d, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err_s);
        longint      off;
        int          n, first, lat, pos, b;
        bit          got, e, is_stdout, is_exit;
        logic [31:0] exp_rd, exp_mask;

        off       = longint'(a) - longint'(BASE);
        n         = (sz == 2'b00) ? 4 : ((sz == 2'b01) ? 2 : 1);
        is_stdout = MMIO && wr && (a == STDOUT);
        is_exit   = MMIO && wr && (a == EXIT);
        e         = !(is_stdout || is_exit) && (off < 0 || off >= DEPTH || (off % n) != 0);
        first     = 0;
        if (!e) begin
            if (n == 4)      first = int'(off);
            else if (n == 2) first = int'(off / 4) * 4 + 2 - int'(off % 4);
            else             first = int'(off / 4) * 4 + 3 - int'(off % 4);
        end
        exp_rd   = '0;
        exp_mask = '1;
        if (!wr && !e) begin
            for (int k = 0; k < n; k++) begin
                pos = 8 * (n - 1 - k);
                if (known_m[d][first + k]) exp_rd[pos +: 8] = mem_m[d][first + k];
                else                       exp_mask[pos +: 8] = 8'h00;
            end
        end

        @(negedge clk);
        mreq[d] = 1'b1; write[d] = wr; size[d] = sz; dad[d] = a; din[d] = wd;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (ackn[d] === 1'b0) got = 1'b1;
        end
        rd    = dout[d];
        err_s = err[d];
        if (!got) begin
            check($sformatf("d%0d_ack_timeout", d), 32'd0, 32'd1, '1);
            mreq[d] = 1'b0;
            return;
        end
        check($sformatf("d%0d_latency", d), 32'(lat), 32'(lat_of(d)), '1);
        check($sformatf("d%0d_err", d), 32'(err[d]), 32'(err_m[d] | e), '1);
        check($sformatf("d%0d_oe", d), 32'(oe[d]), 32'(!wr), '1);
        if (!wr) check($sformatf("d%0d_load@%08h", d, a), dout[d], exp_rd, exp_mask);
        check($sformatf("d%0d_con_valid", d), 32'(cv[d]), 32'(is_stdout), '1);
        if (is_stdout) check($sformatf("d%0d_con_char", d), 32'(cc[d]), 32'(wd[7:0]), '1);
        check($sformatf("d%0d_exit_req", d), 32'(ex[d]), 32'(ex_m[d] | is_exit), '1);
        mreq[d] = 1'b0;

        @(negedge clk);
        check($sformatf("d%0d_ack_one_cycle", d), 32'(ackn[d]), 32'd1, '1);
        check($sformatf("d%0d_oe_drop", d), 32'(oe[d]), 32'd0, '1);
        check($sformatf("d%0d_con_valid_drop", d), 32'(cv[d]), 32'd0, '1);

        if (wr && !e && !is_stdout && !is_exit) begin
            for (int k = 0; k < n; k++) begin
                b = first + k;
                mem_m[d][b]   = wd[8 * (n - 1 - k) +: 8];
                known_m[d][b] = 1'b1;
            end
        end
        err_m[d] = err_m[d] | e;
        ex_m[d]  = ex_m[d] | is_exit;
    endtask

    function automatic vec_t mk(int d, logic wr, logic [1:0] sz, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] exp_rd, logic exp_err);
        vec_t v;
        v = '{d, wr, sz, a, wd, exp_rd, exp_err};
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl [14];
        logic [31:0] rd;
        logic        es;
        int          ack_at [3];
        int          nack, lows;
        logic [1:0]  sz;
        logic        wr;
        int unsigned off, r;
        logic [31:0] a;

        tbl[0]  = mk(0, 1'b1, 2'b00, BASE,          32'h1122_3344, 32'h0,         1'b0);
        tbl[1]  = mk(0, 1'b0, 2'b10, BASE,          32'h0,         32'h0000_0044, 1'b0);
        tbl[2]  = mk(0, 1'b0, 2'b10, BASE + 32'd3,  32'h0,         32'h0000_0011, 1'b0);
        tbl[3]  = mk(0, 1'b1, 2'b01, BASE + 32'd2,  32'h0000_beef, 32'h0,         1'b0);
        tbl[4]  = mk(0, 1'b0, 2'b00, BASE,          32'h0,         32'hbeef_3344, 1'b0);
        tbl[5]  = mk(0, 1'b0, 2'b01, BASE,          32'h0,         32'h0000_3344, 1'b0);
        tbl[6]  = mk(0, 1'b0, 2'b01, BASE + 32'd2,  32'h0,         32'h0000_beef, 1'b0);
        tbl[7]  = mk(1, 1'b1, 2'b00, BASE + 32'd8,  32'ha5a5_5a5a, 32'h0,         1'b0);
        tbl[8]  = mk(1, 1'b0, 2'b00, BASE + 32'd8,  32'h0,         32'ha5a5_5a5a, 1'b0);
        tbl[9]  = mk(1, 1'b0, 2'b11, BASE + 32'd9,  32'h0,         32'h0000_005a, 1'b0);
        tbl[10] = mk(1, 1'b1, 2'b10, STDOUT,        32'h0000_0041, 32'h0,         !MMIO);
        tbl[11] = mk(1, 1'b1, 2'b00, EXIT,          32'h0000_0001, 32'h0,         !MMIO);
        tbl[12] = mk(1, 1'b0, 2'b00, BASE + 32'd1,  32'h0,         32'h0,         1'b1);
        tbl[13] = mk(1, 1'b0, 2'b00, BASE + DEPTH,  32'h0,         32'h0,         1'b1);

        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            mreq[d] = 1'b0; write[d] = 1'b0; size[d] = 2'b00; dad[d] = '0; din[d] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            access(tbl[i].d, tbl[i].wr, tbl[i].sz, tbl[i].a, tbl[i].wd, rd, es);
            if (!tbl[i].wr) check($sformatf("tbl%0d_data", i), rd, tbl[i].exp_rd, '1);
            check($sformatf("tbl%0d_err", i), 32'(es), 32'(tbl[i].exp_err), '1);
        end

        // MREQ held high on the LATENCY=3 instance: an ack every fourth edge.
        ack_at = '{0, 0, 0};
        nack   = 0;
        @(negedge clk);
        mreq[1] = 1'b1; write[1] = 1'b0; size[1] = 2'b00; dad[1] = BASE + 32'd8;
        for (int c = 1; c <= 30 && nack < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ackn[1] === 1'b0) begin
                check($sformatf("b2b_data%0d", nack), dout[1], 32'ha5a5_5a5a, '1);
                ack_at[nack] = c;
                nack++;
            end
        end
        mreq[1] = 1'b0;
        check("b2b_count", 32'(nack), 32'd3, '1);
        check("b2b_ack0", 32'(ack_at[0]), 32'd3, '1);
        check("b2b_ack1", 32'(ack_at[1]), 32'd7, '1);
        check("b2b_ack2", 32'(ack_at[2]), 32'd11, '1);

        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 60; i++) begin
                sz  = 2'($urandom_range(0, 3));
                wr  = 1'($urandom_range(0, 1));
                off = $urandom_range(0, 63) * 4;
                if (sz == 2'b01)      off += 2 * $urandom_range(0, 1);
                else if (sz[1])       off += $urandom_range(0, 3);
                r = $urandom_range(0, 99);
                if (r < 5)       a = BASE + 32'(off) + 32'd1;
                else if (r < 8)  a = BASE + DEPTH + 32'(off);
                else if (r < 10) a = BASE - 32'd4 - 32'(off);
                else             a = BASE + 32'(off);
                access(d, wr, sz, a, $urandom, rd, es);
            end
        end

        // Store aborted by MREQ dropping in WAIT must leave memory untouched.
        access(2, 1'b1, 2'b00, BASE + 32'h10, 32'hcafe_f00d, rd, es);
        @(negedge clk);
        mreq[2] = 1'b1; write[2] = 1'b1; size[2] = 2'b00; dad[2] = BASE + 32'h10; din[2] = 32'h1234_5678;
        lows = 0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            if (ackn[2] !== 1'b1) lows++;
        end
        mreq[2] = 1'b0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (ackn[2] !== 1'b1) lows++;
        end
        check("abort_no_ack", 32'(lows), 32'd0, '1);
        access(2, 1'b0, 2'b00, BASE + 32'h10, 32'h0, rd, es);
        check("abort_mem_kept", rd, 32'hcafe_f00d, '1);

        // Reset in the middle of a WAIT: outputs to reset values, no partial store.
        @(negedge clk);
        mreq[2] = 1'b1; write[2] = 1'b1; size[2] = 2'b00; dad[2] = BASE + 32'h10; din[2] = 32'h0bad_beef;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        check_reset_outputs("midwait");
        mreq[2] = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            err_m[d] = 1'b0;
            ex_m[d]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        access(2, 1'b0, 2'b00, BASE + 32'h10, 32'h0, rd, es);
        check("reset_mem_kept", rd, 32'hcafe_f00d, '1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lat_dmem_slave.md
# lat_dmem_slave

Parametrised data-memory bus slave for the processor's data port (MREQ/WRITE/SIZE/DAD/DDT/ACKD_n), replacing the testbench-only behavioural memory with a clocked, synthesisable-style responder. It provides configurable data width, depth, base address and access latency, plus big-endian byte-lane mapping for word, half and byte accesses. It adds an error flag for misaligned and out-of-range accesses, and an optional memory-mapped stdout/exit port. It sits between the core's data interface and the simulation top, one instance per data port.

## Interface
- `DATA_W`, default 32: data bus width; must be 32 (byte-lane map fixed to 4 lanes).
- `DEPTH_B`, default 65536: storage size in bytes; power of two, ≥ 4.
- `BASE_ADDR`, default 32'h8000_0000: first byte address served.
- `LATENCY`, default 1: MREQ-high cycles until acknowledge; range 1..15.
- `STDOUT_ADDR`, default 32'hf000_0000: byte-store console address (MMIO build only).
- `EXIT_ADDR`, default 32'hff00_0000: store-to-exit address (MMIO build only).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `MREQ` in 1: access request, held until acknowledged.
- `WRITE` in 1: 1 = store, 0 = load; stable while MREQ high.
- `SIZE` in 2: 00 word, 01 half, 10/11 byte.
- `DAD` in 32: byte address; stable while MREQ high.
- `DDT_in` in 32: store data; half in [15:0], byte in [7:0].
- `DDT_out` out 32: load data, zero-extended for half/byte.
- `DDT_oe` out 1: high when DDT_out drives the bus.
- `ACKD_n` out 1: active-low acknowledge, one cycle.
- `err` out 1: sticky access error.
- `con_valid` out 1: one-cycle console strobe (MMIO build).
- `con_char` out 8: console character (MMIO build).
- `exit_req` out 1: sticky exit request (MMIO build).

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE + MREQ=1: capture WRITE, SIZE and DAD; load counter with LATENCY-1. Go to ACK if the counter is 0, else WAIT.
- WAIT: decrement each cycle while MREQ=1. At 0, go to ACK. If MREQ drops, abort to IDLE with no ack and no write.
- ACK: ACKD_n=0 for exactly one cycle. The store commits on entry to ACK; DDT_out/DDT_oe are valid for loads. Next state is IDLE. MREQ still high in IDLE starts a new request (back-to-back throughput = LATENCY+1 cycles).
- Offset off = DAD - BASE_ADDR.
- Word access: bytes off..off+3 map to DDT[31:24]..[7:0].
- Half access: byte index {off[..2],2'b10} - off[1:0] (and +1) maps to DDT[15:8], [7:0].
- Byte access: byte index {off[..2],2'b11} - off[1:0] maps to DDT[7:0].
- Errors:
  - Word access with off[1:0]≠0, or half access with off[0]≠0, sets err.
  - Address outside [BASE_ADDR, BASE_ADDR+DEPTH_B) sets err.
  - Errored accesses are still acknowledged; a load returns 0 and a store writes nothing.
- WRITE or SIZE changing mid-request is ignored; the captured values are used.

## Timing
- Reset values: ACKD_n=1, DDT_out=0, DDT_oe=0, err=0, con_valid=0, con_char=0, exit_req=0, FSM=IDLE.
- Storage contents are not reset.
- Reset asserted mid-request drops the request; no partial store occurs.
- Load latency: ACKD_n falls LATENCY edges after the first edge sampling MREQ=1. All outputs are registered.
- DDT_oe is high only in the ACK cycle of a load.

## Configuration
- `LAT_DMEM_MMIO_EN` defined:
  - A store to STDOUT_ADDR pulses con_valid with con_char=DDT_in[7:0], at any SIZE. Nothing is stored.
  - A store to EXIT_ADDR sets exit_req.
  - Both accesses are acknowledged normally and do not set err.
- `LAT_DMEM_MMIO_EN` undefined: con_valid, con_char and exit_req are tied 0, and both addresses follow the normal range check.

## Structure
- Package `lat_dmem_pkg`: SIZE encodings, FSM state enum, default STDOUT/EXIT addresses.
- Sub-module `lat_dmem_lane`: combinational offset→byte-index and DDT packing/unpacking for word, half and byte accesses, shared by the load and store paths.

## Test plan
- LATENCY=1: store word 0x11223344 @0x8000_0000, then byte load @0x8000_0000 → DDT_out=0x00000044. Byte load @+3 → 0x11.
- LATENCY=3: word load → ACKD_n low exactly on the 3rd MREQ-high edge, for one cycle. Back-to-back loads → ACK every 4 cycles.
- Half store 0xBEEF @+2, then word load @0 → 0xBEEF3344.
- MREQ dropped in WAIT (LATENCY=4, drop after 2 cycles) → no ack, memory unchanged. Reset mid-WAIT → all outputs at reset values.
- Word load @0x8000_0001 and @BASE+DEPTH_B → ack, DDT_out=0, err=1.
- MMIO: byte store 0x41 @0xf000_0000 → con_valid one cycle, con_char=0x41. Store @0xff00_0000 → exit_req=1. Without the macro: err=1.
